riscv_mc_ctrl: RTL and testbench

Multicycle control unit for the single-memory RISC-V datapath (register file, ALU, shared instruction/data memory, PC/IR/old-PC/data/ALU-out registers). A Moore state machine steps each instruction through FETCH, DECODE and one to three execute states. Every cycle it drives all datapath write enables, mux selects and the ALU operation. It replaces the single-cycle decoder when the core is built multicycle; it holds no architectural state beyond its own state register.

---
 rtl/riscv_mc_ctrl_pkg.sv | 60 ++++++
 rtl/riscv_mc_ctrl_if.sv | 30 +++
 rtl/riscv_mc_ctrl_alu_dec.sv | 36 +++
 rtl/riscv_mc_ctrl.sv | 137 +++++++++++++
 tb/tb_riscv_mc_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
// Contains the state enum, opcodes, datapath mux encodings and the branch condition helper.
package riscv_mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH
    } mc_state_e;

    typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;

    typedef enum logic [1:0] {SEL_ADD, SEL_SUB, SEL_FUNCT} alu_sel_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_DATA   = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;

    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Flags come from rs1 - rs2; the reserved codes 010/011 fall through to not-taken.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic [3:0] flags);
        logic n, z, c, v;
        {n, z, c, v} = flags;
        case (funct3)
            F3_BEQ:  return z;
            F3_BNE:  return !z;
            F3_BLT:  return n ^ v;
            F3_BGE:  return !(n ^ v);
            F3_BLTU: return !c;
            F3_BGEU: return c;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mc_ctrl_if.sv
// Control bus between the multicycle controller (master) and the datapath (slave).
interface riscv_mc_ctrl_if;
    logic [6:0]                    op;
    logic [2:0]                    funct3;
    logic                          funct7b5;
    logic [3:0]                    alu_flags;
    logic                          pc_we;
    logic                          adr_src;
    logic                          mem_we;
    logic                          ir_we;
    logic                          reg_we;
    logic [1:0]                    res_src;
    logic [1:0]                    alu_src_a;
    logic [1:0]                    alu_src_b;
    riscv_mc_ctrl_pkg::imm_src_e   imm_src;
    riscv_mc_ctrl_pkg::alu_op_e    alu_ctrl;
    logic                          illegal;

    modport master (
        input  op, funct3, funct7b5, alu_flags,
        output pc_we, adr_src, mem_we, ir_we, reg_we, res_src,
               alu_src_a, alu_src_b, imm_src, alu_ctrl, illegal
    );

    modport slave (
        output op, funct3, funct7b5, alu_flags,
        input  pc_we, adr_src, mem_we, ir_we, reg_we, res_src,
               alu_src_a, alu_src_b, imm_src, alu_ctrl, illegal
    );
endinterface

// File: rtl/riscv_mc_ctrl_alu_dec.sv
// ALU operation decoder: forced ADD/SUB or a decode of funct3/funct7b5.
module mc_alu_dec
    import riscv_mc_ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  alu_sel_e   alu_op_sel,
    output alu_op_e    alu_ctrl
);
    logic is_rtype;

    // addi shares funct3=000 with sub, so only the register form may subtract.
    assign is_rtype = (op == OP_RTYPE);

    always_comb begin
        alu_ctrl = ALU_ADD;
        unique case (alu_op_sel)
            SEL_ADD: alu_ctrl = ALU_ADD;
            SEL_SUB: alu_ctrl = ALU_SUB;
            SEL_FUNCT: begin
                unique case (funct3)
                    3'b000:  alu_ctrl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/riscv_mc_ctrl.sv
// Moore control FSM for the single-memory multicycle RISC-V datapath.
// RISCV_MC_BRANCH_EXT_EN: accept every B-type funct3; otherwise only beq is decoded.
module riscv_mc_ctrl
    import riscv_mc_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    riscv_mc_ctrl_if.master ctl
);
    mc_state_e state_reg, state_next;
    alu_sel_e  alu_sel;
    logic      pc_we_next, mem_we_next, ir_we_next, reg_we_next, illegal_next;
    logic      adr_src_next;
    logic [1:0] res_src_next, src_a_next, src_b_next;
    imm_src_e  imm_src_next;
    logic      branch_ok, taken;

`ifdef RISCV_MC_BRANCH_EXT_EN
    assign branch_ok = 1'b1;
`else
    assign branch_ok = (ctl.funct3 == F3_BEQ);
`endif
    assign taken = branch_taken(ctl.funct3, ctl.alu_flags);

    always_ff @(posedge clk) begin
        if (!rst)
            state_reg <= S_FETCH;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next   = S_FETCH;
        pc_we_next   = 1'b0;
        mem_we_next  = 1'b0;
        ir_we_next   = 1'b0;
        reg_we_next  = 1'b0;
        illegal_next = 1'b0;
        adr_src_next = 1'b0;
        res_src_next = RES_ALUOUT;
        src_a_next   = SRCA_PC;
        src_b_next   = SRCB_RS2;
        imm_src_next = IMM_I;
        alu_sel      = SEL_ADD;
        unique case (state_reg)
            S_FETCH: begin
                ir_we_next   = 1'b1;
                pc_we_next   = 1'b1;
                res_src_next = RES_ALU;
                src_b_next   = SRCB_FOUR;
                state_next   = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is computed speculatively and held in ALU-out.
                src_a_next   = SRCA_OLDPC;
                src_b_next   = SRCB_IMM;
                imm_src_next = IMM_B;
                unique case (ctl.op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_JAL:            state_next = S_JAL;
                    OP_BRANCH: begin
                        state_next   = branch_ok ? S_BRANCH : S_FETCH;
                        illegal_next = !branch_ok;
                    end
                    default:           illegal_next = 1'b1;
                endcase
            end
            S_MEMADR: begin
                src_a_next   = SRCA_RS1;
                src_b_next   = SRCB_IMM;
                imm_src_next = (ctl.op == OP_STORE) ? IMM_S : IMM_I;
                state_next   = (ctl.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src_next = 1'b1;
                state_next   = S_MEMWB;
            end
            S_MEMWB: begin
                res_src_next = RES_DATA;
                reg_we_next  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_next = 1'b1;
                mem_we_next  = 1'b1;
            end
            S_EXECR: begin
                src_a_next = SRCA_RS1;
                alu_sel    = SEL_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                src_a_next = SRCA_RS1;
                src_b_next = SRCB_IMM;
                alu_sel    = SEL_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we_next = 1'b1;
            end
            S_JAL: begin
                src_a_next   = SRCA_OLDPC;
                src_b_next   = SRCB_FOUR;
                imm_src_next = IMM_J;
                pc_we_next   = 1'b1;
                state_next   = S_ALUWB;
            end
            S_BRANCH: begin
                src_a_next = SRCA_RS1;
                alu_sel    = SEL_SUB;
                pc_we_next = taken;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Reset masks every write strobe so an aborted instruction leaves no side effects.
    assign ctl.pc_we     = pc_we_next & rst;
    assign ctl.mem_we    = mem_we_next & rst;
    assign ctl.ir_we     = ir_we_next & rst;
    assign ctl.reg_we    = reg_we_next & rst;
    assign ctl.illegal   = illegal_next & rst;
    assign ctl.adr_src   = adr_src_next;
    assign ctl.res_src   = res_src_next;
    assign ctl.alu_src_a = src_a_next;
    assign ctl.alu_src_b = src_b_next;
    assign ctl.imm_src   = imm_src_next;

    mc_alu_dec u_alu_dec (
        .op         (ctl.op),
        .funct3     (ctl.funct3),
        .funct7b5   (ctl.funct7b5),
        .alu_op_sel (alu_sel),
        .alu_ctrl   (ctl.alu_ctrl)
    );
endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Bench for riscv_mc_ctrl: per-class vector table, reset corner cases, random instruction stream.
module tb_riscv_mc_ctrl;
    import riscv_mc_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    riscv_mc_ctrl_if bus();

    riscv_mc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       pc_we, adr_src, mem_we, ir_we, reg_we, illegal;
        logic [1:0] res_src, src_a, src_b;
        imm_src_e   imm;
        alu_op_e    alu;
    } ctl_t;

    typedef struct packed {
        logic adr, res, alu, imm;
    } care_t;

    ctl_t  exp_q[$];
    care_t care_q[$];

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [3:0] fl;
        int         cyc, ill, rw, mw, pw;
    } tv_t;
    tv_t tbl[$];

    function automatic void add_tv(logic [6:0] op, logic [2:0] f3, logic f7, logic [3:0] fl,
                                   int cyc, int ill, int rw, int mw, int pw);
        tv_t t;
        t.op = op; t.f3 = f3; t.f7 = f7; t.fl = fl;
        t.cyc = cyc; t.ill = ill; t.rw = rw; t.mw = mw; t.pw = pw;
        tbl.push_back(t);
    endfunction

    function automatic ctl_t sample();
        ctl_t s;
        s.pc_we = bus.pc_we;     s.adr_src = bus.adr_src; s.mem_we = bus.mem_we;
        s.ir_we = bus.ir_we;     s.reg_we = bus.reg_we;   s.illegal = bus.illegal;
        s.res_src = bus.res_src; s.src_a = bus.alu_src_a; s.src_b = bus.alu_src_b;
        s.imm = bus.imm_src;     s.alu = bus.alu_ctrl;
        return s;
    endfunction

    // ---- reference model: instruction class -> list of per-cycle control words
    function automatic logic ref_legal(logic [6:0] op, logic [2:0] f3);
        if (op == OP_BRANCH) begin
`ifdef RISCV_MC_BRANCH_EXT_EN
            return 1'b1;
`else
            return f3 == 3'b000;
`endif
        end
        return op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL};
    endfunction

    function automatic alu_op_e ref_alu(logic [2:0] f3, logic f7, logic rtype);
        alu_op_e names [8];
        names = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        if (f3 == 3'd0 && rtype && f7) return ALU_SUB;
        if (f3 == 3'd5 && f7) return ALU_SRA;
        return names[f3];
    endfunction

    function automatic logic ref_taken(logic [2:0] f3, logic [3:0] fl);
        logic n, z, c, v;
        {n, z, c, v} = fl;
        unique case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return n != v;
            3'd5: return n == v;
            3'd6: return !c;
            3'd7: return c;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void push(ctl_t c, care_t k);
        exp_q.push_back(c);
        care_q.push_back(k);
    endfunction

    function automatic void build(logic [6:0] op, logic [2:0] f3, logic f7, logic [3:0] fl);
        ctl_t  c;
        care_t k;
        exp_q.delete(); care_q.delete();
        c = '0; k = '0;
        c.pc_we = 1; c.ir_we = 1; c.res_src = 2; c.src_b = 2; c.alu = ALU_ADD;
        k.adr = 1; k.res = 1; k.alu = 1;
        push(c, k);
        c = '0; k = '0;
        c.src_a = 1; c.src_b = 1; c.imm = IMM_B; c.alu = ALU_ADD; c.illegal = !ref_legal(op, f3);
        k.alu = 1; k.imm = 1;
        push(c, k);
        if (!ref_legal(op, f3)) return;
        c = '0; k = '0;
        if (op == OP_LOAD || op == OP_STORE) begin
            c.src_a = 2; c.src_b = 1; c.alu = ALU_ADD;
            c.imm = (op == OP_STORE) ? IMM_S : IMM_I;
            k.alu = 1; k.imm = 1;
            push(c, k);
            c = '0; k = '0;
            c.adr_src = 1; c.mem_we = (op == OP_STORE);
            k.adr = 1; k.res = 1;
            push(c, k);
            if (op == OP_LOAD) begin
                c = '0; k = '0;
                c.res_src = 1; c.reg_we = 1; k.res = 1;
                push(c, k);
            end
        end else if (op == OP_BRANCH) begin
            c.src_a = 2; c.alu = ALU_SUB; c.pc_we = ref_taken(f3, fl);
            k.alu = 1; k.res = 1;
            push(c, k);
        end else begin
            if (op == OP_JAL) begin
                c.src_a = 1; c.src_b = 2; c.alu = ALU_ADD; c.imm = IMM_J; c.pc_we = 1;
                k.alu = 1; k.imm = 1; k.res = 1;
            end else begin
                c.src_a = 2; c.src_b = (op == OP_ITYPE) ? 2'd1 : 2'd0;
                c.alu = ref_alu(f3, f7, op == OP_RTYPE);
                k.alu = 1; k.imm = (op == OP_ITYPE);
            end
            push(c, k);
            c = '0; k = '0;
            c.reg_we = 1; k.res = 1;
            push(c, k);
        end
    endfunction

    function automatic logic match(ctl_t a, ctl_t e, care_t k);
        if ({a.pc_we, a.mem_we, a.ir_we, a.reg_we, a.illegal} !=
            {e.pc_we, e.mem_we, e.ir_we, e.reg_we, e.illegal}) return 1'b0;
        if (k.adr && a.adr_src != e.adr_src) return 1'b0;
        if (k.res && a.res_src != e.res_src) return 1'b0;
        if (k.alu && {a.src_a, a.src_b, a.alu} != {e.src_a, e.src_b, e.alu}) return 1'b0;
        if (k.imm && a.imm != e.imm) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drive(logic [6:0] op, logic [2:0] f3, logic f7, logic [3:0] fl);
        bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.alu_flags = fl;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a FETCH cycle (1 time unit after the edge); leaves at the next FETCH.
    task automatic run_model(int id, logic [6:0] op, logic [2:0] f3, logic f7, logic [3:0] fl);
        ctl_t a;
        int   bad = 0;
        build(op, f3, f7, fl);
        drive(op, f3, f7, fl);
        foreach (exp_q[i]) begin
            a = sample();
            checks++;
            if (!match(a, exp_q[i], care_q[i])) begin
                errors++; bad++;
                $display("FAIL txn%0d step%0d: got %h expected %h care %b",
                         id, i, a, exp_q[i], care_q[i]);
            end
            @(posedge clk); #1;
        end
        $display("txn %0d op=%b f3=%0d f7=%0b fl=%h cycles=%0d bad=%0d",
                 id, op, f3, f7, fl, exp_q.size(), bad);
    endtask

    task automatic measure(tv_t t, output int cyc, output int ill, output int rw,
                           output int mw, output int pw);
        drive(t.op, t.f3, t.f7, t.fl);
        cyc = 0; ill = 0; rw = 0; mw = 0; pw = 0;
        do begin
            cyc++;
            ill += int'(bus.illegal); rw += int'(bus.reg_we);
            mw += int'(bus.mem_we);   pw += int'(bus.pc_we);
            @(posedge clk); #1;
        end while (!bus.ir_we && cyc < 12);
    endtask

    initial begin
        int cyc, ill, rw, mw, pw;
        logic [6:0] ops [6];
        logic [6:0] op;
        ops = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BRANCH};

        add_tv(OP_RTYPE,  3'd0, 1'b1, 4'h0, 4, 0, 1, 0, 1);  // sub
        add_tv(OP_LOAD,   3'd2, 1'b0, 4'h0, 5, 0, 1, 0, 1);  // lw
        add_tv(OP_STORE,  3'd2, 1'b0, 4'h0, 4, 0, 0, 1, 1);  // sw
        add_tv(OP_ITYPE,  3'd0, 1'b1, 4'h0, 4, 0, 1, 0, 1);  // addi
        add_tv(OP_ITYPE,  3'd5, 1'b1, 4'h0, 4, 0, 1, 0, 1);  // srai
        add_tv(OP_JAL,    3'd0, 1'b0, 4'h0, 4, 0, 1, 0, 2);  // jal
        add_tv(OP_BRANCH, 3'd0, 1'b0, 4'h4, 3, 0, 0, 0, 2);  // beq equal
        add_tv(OP_BRANCH, 3'd0, 1'b0, 4'h0, 3, 0, 0, 0, 1);  // beq unequal
        add_tv(7'h00,     3'd0, 1'b0, 4'h0, 2, 1, 0, 0, 1);  // all-zero word
        add_tv(7'b0110111, 3'd0, 1'b0, 4'h0, 2, 1, 0, 0, 1); // lui unsupported
`ifdef RISCV_MC_BRANCH_EXT_EN
        add_tv(OP_BRANCH, 3'd1, 1'b0, 4'h8, 3, 0, 0, 0, 2);  // bne 1,2 taken
        add_tv(OP_BRANCH, 3'd2, 1'b0, 4'h0, 3, 0, 0, 0, 1);  // reserved, never taken
`else
        add_tv(OP_BRANCH, 3'd1, 1'b0, 4'h8, 2, 1, 0, 0, 1);  // bne undecoded
`endif

        // reset hold: all strobes low
        drive(7'h00, 3'd0, 1'b0, 4'h0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold_strobes", {27'd0, bus.pc_we, bus.ir_we, bus.mem_we, bus.reg_we, bus.illegal}, 32'd0);
        rst = 1'b1;
        #1;
        chk("reset_release_fetch", {30'd0, bus.ir_we, bus.pc_we}, 32'd3);
        @(posedge clk); #1;
        // now in DECODE of the all-zero word: illegal high, then masked by reset
        chk("illegal_pulse", {31'd0, bus.illegal}, 32'd1);
        rst = 1'b0;
        #1;
        chk("illegal_masked_by_reset", {31'd0, bus.illegal}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;

        foreach (tbl[i]) begin
            measure(tbl[i], cyc, ill, rw, mw, pw);
            checks++;
            if (cyc != tbl[i].cyc || ill != tbl[i].ill || rw != tbl[i].rw ||
                mw != tbl[i].mw || pw != tbl[i].pw) begin
                errors++;
                $display("FAIL vec%0d: got cyc=%0d ill=%0d rw=%0d mw=%0d pw=%0d expected cyc=%0d ill=%0d rw=%0d mw=%0d pw=%0d",
                         i, cyc, ill, rw, mw, pw, tbl[i].cyc, tbl[i].ill, tbl[i].rw, tbl[i].mw, tbl[i].pw);
            end
            $display("vec %0d op=%b f3=%0d cycles=%0d", i, tbl[i].op, tbl[i].f3, cyc);
        end

        // lw aborted by reset in MEMREAD
        drive(OP_LOAD, 3'd2, 1'b0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("lw_memread_adr", {31'd0, bus.adr_src}, 32'd1);
        rst = 1'b0;
        #1;
        chk("lw_abort_strobes", {27'd0, bus.pc_we, bus.ir_we, bus.mem_we, bus.reg_we, bus.illegal}, 32'd0);
        @(posedge clk); #1;
        chk("lw_abort_next_cycle", {27'd0, bus.pc_we, bus.ir_we, bus.mem_we, bus.reg_we, bus.illegal}, 32'd0);
        rst = 1'b1;
        #1;
        run_model(-1, OP_LOAD, 3'd2, 1'b0, 4'h0);

        for (int n = 0; n < 200; n++) begin
            int k = $urandom_range(0, 7);
            if (k < 6) op = ops[k];
            else op = 7'($urandom);
            run_model(n, op, 3'($urandom), 1'($urandom), 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
